// File: rtl/id_ex_stage_pkg.sv
// Shared LC-3b datapath types for the decode-to-execute stage.
// Every immediate/offset the EX stage consumes is grouped so it can be registered as one unit.
package id_ex_stage_pkg;

    localparam int LC3B_WORD_W = 16;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [2:0]             lc3b_reg;
    typedef logic [10:0]            lc3b_ir_10_0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] aluop;
        logic       ld_reg;
        logic       ld_cc;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] pcmux_sel;
        logic [1:0] marmux_sel;
        logic       br_en;
        logic       byte_op;
    } lc3b_control_word;

    typedef struct packed {
        lc3b_word   sext5;
        lc3b_word   sext6;
        lc3b_word   adj6;
        lc3b_word   adj9;
        lc3b_word   adj11;
        lc3b_word   trap;
        logic [3:0] imm4;
    } lc3b_imm_t;

endpackage

// File: rtl/id_ex_stage_imm.sv
// Combinational immediate/offset extension for IR[10:0].
// The sign bit is always the top bit of the field; adjusted offsets are word offsets (LSB 0).
module imm_ext_unit
    import id_ex_stage_pkg::*;
(
    input  lc3b_ir_10_0 ir_i,
    output lc3b_imm_t   imm_o
);

    always_comb begin
        imm_o.sext5 = {{11{ir_i[4]}}, ir_i[4:0]};
        imm_o.sext6 = {{10{ir_i[5]}}, ir_i[5:0]};
        imm_o.adj6  = {{9{ir_i[5]}}, ir_i[5:0], 1'b0};
        imm_o.adj9  = {{6{ir_i[8]}}, ir_i[8:0], 1'b0};
        imm_o.adj11 = {{4{ir_i[10]}}, ir_i[10:0], 1'b0};
        // Trap vector is zero-extended, so the upper 7 bits stay clear.
        imm_o.trap  = {7'b0, ir_i[7:0], 1'b0};
        imm_o.imm4  = ir_i[3:0];
    end

endmodule

// File: rtl/id_ex_stage.sv
// LC-3b decode-to-execute pipeline register with valid/ready handshake, stall and flush.
// Also counts back-pressure cycles (saturating) for performance debug.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  lc3b_control_word    id_ctrl,
    input  logic [WORD_W-1:0]   id_pc,
    input  logic [WORD_W-1:0]   id_sr1,
    input  logic [WORD_W-1:0]   id_sr2,
    input  logic [2:0]          id_dest,
    input  logic [10:0]         id_ir,
    output logic                ex_valid,
    input  logic                ex_ready,
    output lc3b_control_word    ex_ctrl,
    output logic [WORD_W-1:0]   ex_pc,
    output logic [WORD_W-1:0]   ex_sr1,
    output logic [WORD_W-1:0]   ex_sr2,
    output logic [2:0]          ex_dest,
    output logic [WORD_W-1:0]   ex_sext5,
    output logic [WORD_W-1:0]   ex_sext6,
    output logic [WORD_W-1:0]   ex_adj6,
    output logic [WORD_W-1:0]   ex_adj9,
    output logic [WORD_W-1:0]   ex_adj11,
    output logic [WORD_W-1:0]   ex_trap,
    output logic [3:0]          ex_imm4,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic              valid_q, valid_d;
    lc3b_control_word  ctrl_q;
    logic [WORD_W-1:0] pc_q, sr1_q, sr2_q;
    lc3b_reg           dest_q;
    lc3b_imm_t         imm_d, imm_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              capture;
    logic              stalling;

    imm_ext_unit u_imm (
        .ir_i  (id_ir),
        .imm_o (imm_d)
    );

    // A flush accepts and discards the incoming instruction, so it also opens the input.
    assign id_ready = !valid_q || ex_ready || flush;
    assign capture  = id_valid && id_ready && !flush;
    assign stalling = valid_q && !ex_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            dest_q  <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (capture) begin
                ctrl_q <= id_ctrl;
                pc_q   <= id_pc;
                sr1_q  <= id_sr1;
                sr2_q  <= id_sr2;
                dest_q <= id_dest;
                imm_q  <= imm_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stalling && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_pc     = pc_q;
    assign ex_sr1    = sr1_q;
    assign ex_sr2    = sr2_q;
    assign ex_dest   = dest_q;
    assign ex_sext5  = imm_q.sext5;
    assign ex_sext6  = imm_q.sext6;
    assign ex_adj6   = imm_q.adj6;
    assign ex_adj9   = imm_q.adj9;
    assign ex_adj11  = imm_q.adj11;
    assign ex_trap   = imm_q.trap;
    assign ex_imm4   = imm_q.imm4;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: extensions, stall, flush, streaming, saturation, async reset.
// A 4-bit stall counter makes saturation reachable in a handful of cycles.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    lc3b_control_word  id_ctrl;
    logic [WORD_W-1:0] id_pc, id_sr1, id_sr2;
    logic [2:0]        id_dest;
    logic [10:0]       id_ir;
    logic              ex_valid;
    logic              ex_ready;
    lc3b_control_word  ex_ctrl;
    logic [WORD_W-1:0] ex_pc, ex_sr1, ex_sr2;
    logic [2:0]        ex_dest;
    logic [WORD_W-1:0] ex_sext5, ex_sext6, ex_adj6, ex_adj9, ex_adj11, ex_trap;
    logic [3:0]        ex_imm4;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_dest(id_dest), .id_ir(id_ir),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_dest(ex_dest),
        .ex_sext5(ex_sext5), .ex_sext6(ex_sext6), .ex_adj6(ex_adj6),
        .ex_adj9(ex_adj9), .ex_adj11(ex_adj11), .ex_trap(ex_trap),
        .ex_imm4(ex_imm4), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [15:0] ctrl, input logic [15:0] pc,
                                 input logic [15:0] sr1, input logic [15:0] sr2,
                                 input logic [2:0] dest, input logic [10:0] ir,
                                 input logic exr, input logic fl);
        id_valid = v;
        id_ctrl  = lc3b_control_word'(ctrl);
        id_pc    = pc;
        id_sr1   = sr1;
        id_sr2   = sr2;
        id_dest  = dest;
        id_ir    = ir;
        ex_ready = exr;
        flush    = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 11'h0, 1'b0, 1'b0);
        #12;
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("rst_cnt", {28'b0, stall_cnt}, 32'd0);
        checkOutput("rst_pc", {16'b0, ex_pc}, 32'd0);
        checkOutput("rst_sext5", {16'b0, ex_sext5}, 32'd0);
        checkOutput("rst_ready", {31'b0, id_ready}, 32'd1);
        reset = 1'b0;

        applyStimulus(1'b1, 16'hA5C3, 16'h3002, 16'h1111, 16'h2222, 3'd5, 11'h01F, 1'b1, 1'b0);
        step();
        checkOutput("t1_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("t1_sext5", {16'b0, ex_sext5}, 32'h0000FFFF);
        checkOutput("t1_sext6", {16'b0, ex_sext6}, 32'h0000001F);
        checkOutput("t1_adj6", {16'b0, ex_adj6}, 32'h0000003E);
        checkOutput("t1_adj9", {16'b0, ex_adj9}, 32'h0000003E);
        checkOutput("t1_trap", {16'b0, ex_trap}, 32'h0000003E);
        checkOutput("t1_imm4", {28'b0, ex_imm4}, 32'hF);
        checkOutput("t1_ctrl", {16'b0, ex_ctrl}, 32'h0000A5C3);
        checkOutput("t1_pc", {16'b0, ex_pc}, 32'h00003002);
        checkOutput("t1_sr1", {16'b0, ex_sr1}, 32'h00001111);
        checkOutput("t1_sr2", {16'b0, ex_sr2}, 32'h00002222);
        checkOutput("t1_dest", {29'b0, ex_dest}, 32'd5);

        applyStimulus(1'b1, 16'h0F0F, 16'h3004, 16'h0, 16'h0, 3'd1, 11'h400, 1'b1, 1'b0);
        step();
        checkOutput("t2_adj11_400", {16'b0, ex_adj11}, 32'h0000F800);
        checkOutput("t2_adj9_400", {16'b0, ex_adj9}, 32'h00000000);
        checkOutput("t2_trap_400", {16'b0, ex_trap}, 32'h00000000);
        applyStimulus(1'b1, 16'h0F0F, 16'h3006, 16'h0, 16'h0, 3'd2, 11'h1FF, 1'b1, 1'b0);
        step();
        checkOutput("t2_trap_1ff", {16'b0, ex_trap}, 32'h000001FE);
        checkOutput("t2_adj9_1ff", {16'b0, ex_adj9}, 32'h0000FFFE);
        checkOutput("t2_adj11_1ff", {16'b0, ex_adj11}, 32'h000003FE);
        checkOutput("t2_sext6_1ff", {16'b0, ex_sext6}, 32'h0000FFFF);
        checkOutput("t2_adj6_1ff", {16'b0, ex_adj6}, 32'h0000FFFE);
        applyStimulus(1'b1, 16'h0F0F, 16'h3008, 16'h0, 16'h0, 3'd3, 11'h0FF, 1'b1, 1'b0);
        step();
        checkOutput("t2_trap_0ff", {16'b0, ex_trap}, 32'h000001FE);
        checkOutput("t2_adj9_0ff", {16'b0, ex_adj9}, 32'h000001FE);

        applyStimulus(1'b1, 16'h1234, 16'h300A, 16'h0, 16'h0, 3'd4, 11'h0AA, 1'b0, 1'b0);
        #1;
        checkOutput("t3_ready_low", {31'b0, id_ready}, 32'd0);
        repeat (5) step();
        checkOutput("t3_hold_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("t3_hold_pc", {16'b0, ex_pc}, 32'h00003008);
        checkOutput("t3_hold_adj9", {16'b0, ex_adj9}, 32'h000001FE);
        checkOutput("t3_cnt5", {28'b0, stall_cnt}, 32'd5);
        ex_ready = 1'b1;
        #1;
        checkOutput("t3_ready_high", {31'b0, id_ready}, 32'd1);
        step();
        checkOutput("t3_load_pc", {16'b0, ex_pc}, 32'h0000300A);
        checkOutput("t3_load_sext5", {16'b0, ex_sext5}, 32'h0000000A);
        checkOutput("t3_cnt_kept", {28'b0, stall_cnt}, 32'd5);

        applyStimulus(1'b1, 16'hFFFF, 16'h300C, 16'h0, 16'h0, 3'd6, 11'h7FF, 1'b0, 1'b1);
        #1;
        checkOutput("t4_ready_flush", {31'b0, id_ready}, 32'd1);
        step();
        checkOutput("t4_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("t4_cnt", {28'b0, stall_cnt}, 32'd5);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 11'h0, 1'b0, 1'b0);
        step();
        checkOutput("t4_still_empty", {31'b0, ex_valid}, 32'd0);
        checkOutput("t4_pc_dropped", {16'b0, ex_pc}, 32'h0000300A);
        checkOutput("t4_cnt_idle", {28'b0, stall_cnt}, 32'd5);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(i), 16'h3100 + 16'(2 * i), 16'h0, 16'h0, 3'(i), 11'(i), 1'b1, 1'b0);
            step();
            checkOutput($sformatf("t5_valid_%0d", i), {31'b0, ex_valid}, 32'd1);
            checkOutput($sformatf("t5_pc_%0d", i), {16'b0, ex_pc}, 32'h00003100 + 32'(2 * i));
        end
        id_valid = 1'b0;
        step();
        checkOutput("t5_drain", {31'b0, ex_valid}, 32'd0);
        checkOutput("t5_pc_hold", {16'b0, ex_pc}, 32'h00003106);

        applyStimulus(1'b1, 16'h0, 16'h3200, 16'h0, 16'h0, 3'd0, 11'h0, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 11'h0, 1'b0, 1'b0);
        repeat (10) step();
        checkOutput("sat_15", {28'b0, stall_cnt}, 32'd15);
        repeat (3) step();
        checkOutput("sat_hold", {28'b0, stall_cnt}, 32'd15);
        checkOutput("sat_valid", {31'b0, ex_valid}, 32'd1);

        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("t6_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("t6_cnt", {28'b0, stall_cnt}, 32'd0);
        checkOutput("t6_pc", {16'b0, ex_pc}, 32'd0);
        #1 reset = 1'b0;
        #1;
        checkOutput("t6_ready", {31'b0, id_ready}, 32'd1);
        applyStimulus(1'b1, 16'h0001, 16'h3300, 16'h0, 16'h0, 3'd7, 11'h010, 1'b1, 1'b0);
        step();
        checkOutput("t6_recap_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("t6_recap_pc", {16'b0, ex_pc}, 32'h00003300);
        checkOutput("t6_recap_sext5", {16'b0, ex_sext5}, 32'h0000FFF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
